// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use, multi-cycle and taken-branch hazard control.
// Also keeps a saturating count of the cycles in which ID is stalled.
module id_ex_hazard_stage #(
    parameter int REG_AW    = 5,
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_multicycle,
    input  logic              ex_branch_taken,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_if_id,
    output logic              id_ex_valid,
    output logic [REG_AW-1:0] id_ex_rs1,
    output logic [REG_AW-1:0] id_ex_rs2,
    output logic [REG_AW-1:0] id_ex_rd,
    output logic              id_ex_reg_write,
    output logic              id_ex_mem_read,
    output logic              ex_busy,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {RUN, MC_BUSY} state_t;

    localparam logic [3:0] MC_INIT = 4'(MC_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        mc_cnt_q, mc_cnt_d;
    logic              valid_q, valid_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              mr_q, mr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_use;

    assign load_use = id_valid && valid_q && mr_q && (rd_q != '0) &&
                      ((id_uses_rs1 && (id_rs1 == rd_q)) ||
                       (id_uses_rs2 && (id_rs2 == rd_q)));

    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        mr_d        = mr_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_if_id = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_branch_taken || load_use) begin
                    // Flush takes priority; either way ID/EX receives a bubble
                    flush_if_id = ex_branch_taken;
                    stall_if    = !ex_branch_taken;
                    stall_id    = !ex_branch_taken;
                    valid_d     = 1'b0;
                    rs1_d       = '0;
                    rs2_d       = '0;
                    rd_d        = '0;
                    rw_d        = 1'b0;
                    mr_d        = 1'b0;
                end else begin
                    valid_d = id_valid;
                    rs1_d   = id_rs1;
                    rs2_d   = id_rs2;
                    rd_d    = id_rd;
                    rw_d    = id_valid && id_reg_write;
                    mr_d    = id_valid && id_mem_read;
                    if (id_valid && id_multicycle) begin
                        state_d  = MC_BUSY;
                        mc_cnt_d = MC_INIT;
                    end
                end
            end
            MC_BUSY: begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                mc_cnt_d = mc_cnt_q - 4'd1;
                if (mc_cnt_q == 4'd1) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign cnt_d = (stall_id && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
            valid_q  <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            valid_q  <= valid_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign id_ex_valid     = valid_q;
    assign id_ex_rs1       = rs1_q;
    assign id_ex_rs2       = rs2_q;
    assign id_ex_rd        = rd_q;
    assign id_ex_reg_write = rw_q;
    assign id_ex_mem_read  = mr_q;
    assign ex_busy         = (state_q == MC_BUSY);
    assign stall_count     = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench for id_ex_hazard_stage: a stimulus process pushes expectations from a
// cycle-level reference model, a negedge monitor pops and compares them.
module tb_id_ex_hazard_stage;
    localparam int AW = 5;
    localparam int MC = 4;

    logic clk = 0;
    logic rst_n = 0;
    logic id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_reg_write = 0;
    logic id_mem_read = 0, id_multicycle = 0, ex_branch_taken = 0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic stall_if, stall_id, flush_if_id, id_ex_valid, id_ex_reg_write, id_ex_mem_read, ex_busy;
    logic [AW-1:0] id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [15:0] stall_count;
    logic s_if2, s_id2, fl2, v2, rw2, mr2, busy2;
    logic [AW-1:0] rs1_2, rs2_2, rd_2;
    logic [3:0] stall_count4;

    always #5 clk = ~clk;

    id_ex_hazard_stage #(.REG_AW(AW), .MC_CYCLES(MC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
        .ex_branch_taken(ex_branch_taken), .stall_if(stall_if), .stall_id(stall_id),
        .flush_if_id(flush_if_id), .id_ex_valid(id_ex_valid), .id_ex_rs1(id_ex_rs1),
        .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_read(id_ex_mem_read), .ex_busy(ex_busy), .stall_count(stall_count));

    // Narrow-counter twin so saturation is reachable in a short run
    id_ex_hazard_stage #(.REG_AW(AW), .MC_CYCLES(MC), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
        .ex_branch_taken(ex_branch_taken), .stall_if(s_if2), .stall_id(s_id2),
        .flush_if_id(fl2), .id_ex_valid(v2), .id_ex_rs1(rs1_2),
        .id_ex_rs2(rs2_2), .id_ex_rd(rd_2), .id_ex_reg_write(rw2),
        .id_ex_mem_read(mr2), .ex_busy(busy2), .stall_count(stall_count4));

    typedef struct {
        bit v, u1, u2, rw, mr, mc, br;
        int rs1, rs2, rd;
    } in_t;

    typedef struct {
        int s_if, s_id, fl, valid, rs1, rs2, rd, rw, mr, busy, cnt, cnt4;
    } exp_t;

    exp_t q[$];
    int n_pass = 0, n_total = 0;

    // Reference model: ID/EX contents, remaining busy cycles, total stall cycles
    int m_valid, m_rs1, m_rs2, m_rd, m_rw, m_mr, busy_left, stalls;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic drive(input in_t x);
        id_valid = x.v; id_uses_rs1 = x.u1; id_uses_rs2 = x.u2; id_reg_write = x.rw;
        id_mem_read = x.mr; id_multicycle = x.mc; ex_branch_taken = x.br;
        id_rs1 = AW'(x.rs1); id_rs2 = AW'(x.rs2); id_rd = AW'(x.rd);
    endtask

    task automatic cyc(input in_t x);
        exp_t e;
        bit lu, st, fl;
        drive(x);
        lu = x.v && m_valid != 0 && m_mr != 0 && m_rd != 0 &&
             ((x.u1 && x.rs1 == m_rd) || (x.u2 && x.rs2 == m_rd));
        st = 0; fl = 0;
        if (busy_left > 0) st = 1;
        else if (x.br) fl = 1;
        else if (lu) st = 1;
        e.s_if = st; e.s_id = st; e.fl = fl;
        e.valid = m_valid; e.rs1 = m_rs1; e.rs2 = m_rs2; e.rd = m_rd;
        e.rw = m_rw; e.mr = m_mr; e.busy = (busy_left > 0);
        e.cnt = sat(stalls, 65535); e.cnt4 = sat(stalls, 15);
        q.push_back(e);
        if (busy_left > 0) busy_left--;
        else if (st || fl) begin
            m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rw = 0; m_mr = 0;
        end else begin
            m_valid = x.v; m_rs1 = x.rs1; m_rs2 = x.rs2; m_rd = x.rd;
            m_rw = x.v && x.rw; m_mr = x.v && x.mr;
            if (x.v && x.mc) busy_left = MC - 1;
        end
        if (st) stalls++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        exp_t e;
        in_t idle;
        idle = '{default: 0};
        rst_n = 0;
        drive(idle);
        e = '{default: 0};
        q.push_back(e);
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rw = 0; m_mr = 0;
        busy_left = 0; stalls = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    function automatic in_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd,
                               bit rw, bit mr, bit mc, bit br);
        in_t x;
        x.v = v; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2; x.rd = rd;
        x.rw = rw; x.mr = mr; x.mc = mc; x.br = br;
        return x;
    endfunction

    function automatic in_t rnd();
        in_t x;
        x.v  = ($urandom_range(0, 99) < 85);
        x.rs1 = $urandom_range(0, 3); x.rs2 = $urandom_range(0, 3); x.rd = $urandom_range(0, 3);
        x.u1 = $urandom_range(0, 1); x.u2 = $urandom_range(0, 1);
        x.rw = $urandom_range(0, 1);
        x.mr = ($urandom_range(0, 99) < 40);
        x.mc = ($urandom_range(0, 99) < 10);
        x.br = ($urandom_range(0, 99) < 10);
        return x;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_if", int'(stall_if), e.s_if);
                chk("stall_id", int'(stall_id), e.s_id);
                chk("flush_if_id", int'(flush_if_id), e.fl);
                chk("id_ex_valid", int'(id_ex_valid), e.valid);
                chk("id_ex_rs1", int'(id_ex_rs1), e.rs1);
                chk("id_ex_rs2", int'(id_ex_rs2), e.rs2);
                chk("id_ex_rd", int'(id_ex_rd), e.rd);
                chk("id_ex_reg_write", int'(id_ex_reg_write), e.rw);
                chk("id_ex_mem_read", int'(id_ex_mem_read), e.mr);
                chk("ex_busy", int'(ex_busy), e.busy);
                chk("stall_count", int'(stall_count), e.cnt);
                chk("stall_count_sat4", int'(stall_count4), e.cnt4);
            end
        end
    end

    initial begin : stim
        in_t lw5, add5, nop;
        @(posedge clk); #1;
        do_reset();
        lw5  = mk(1, 1, 1, 2, 0, 5, 1, 1, 0, 0);
        add5 = mk(1, 5, 1, 3, 1, 6, 1, 0, 0, 0);
        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use: one stall, bubble, then the add issues
        cyc(lw5); cyc(add5); cyc(add5); cyc(nop);
        // load to x0, and non-reading consumer: no stall
        cyc(mk(1, 1, 1, 2, 0, 0, 1, 1, 0, 0)); cyc(mk(1, 0, 1, 0, 1, 7, 1, 0, 0, 0));
        cyc(lw5); cyc(mk(1, 5, 0, 2, 1, 7, 1, 0, 0, 0)); cyc(nop);
        // multi-cycle op, with branch noise ignored while busy
        cyc(mk(1, 1, 1, 2, 1, 9, 1, 0, 1, 0));
        cyc(mk(1, 9, 1, 9, 1, 3, 1, 0, 0, 1)); cyc(add5); cyc(add5); cyc(add5); cyc(nop);
        // load-use and taken branch together: flush wins
        cyc(lw5); cyc(mk(1, 5, 1, 3, 1, 6, 1, 0, 0, 1)); cyc(nop);
        // repeated load-use stalls to push the narrow counter into saturation
        for (int i = 0; i < 12; i++) begin cyc(lw5); cyc(add5); end
        cyc(nop);
        // reset during the multi-cycle window, then normal issue
        cyc(mk(1, 1, 1, 2, 1, 9, 1, 0, 1, 0)); cyc(nop);
        do_reset();
        cyc(add5); cyc(nop);
        for (int i = 0; i < 400; i++) cyc(rnd());
        do_reset();
        cyc(nop);
        @(negedge clk); @(negedge clk);
        chk("queue_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
